wieg_regelaar: RTL

Closed-loop cradle rocking controller. It consumes the per-interval stress verdict (gedaald / gelijk) from the stress block and adjusts the rocking frequency and amplitude setpoints to the motor driver. It runs a hill-climbing search over the two settings and locks when stress stays level for several consecutive evaluations. It sits between stress and the motor drive, clocked on clk and advanced by the same slow tick.

---
 rtl/wieg_regelaar_pkg.sv | 33 +++
 rtl/wieg_regelaar_if.sv | 35 +++
 rtl/wieg_stap.sv | 40 ++++
 rtl/wieg_regelaar.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wieg_regelaar_pkg.sv
// ============================================================================
// Module   : wieg_regelaar_pkg
// Purpose  : Shared types and default constants for the cradle rocking loop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wieg_regelaar_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_EVAL   = 2'd1,
        ST_STEP   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef enum logic {
        SEL_FREQ = 1'b0,
        SEL_AMP  = 1'b1
    } sel_t;

    localparam int unsigned c_DEF_W            = 4;
    localparam int unsigned c_DEF_FREQ_INIT    = 8;
    localparam int unsigned c_DEF_AMP_INIT     = 4;
    localparam int unsigned c_DEF_VAL_MIN      = 1;
    localparam int unsigned c_DEF_VAL_MAX      = 15;
    localparam int unsigned c_DEF_SETTLE_TICKS = 4;
    localparam int unsigned c_DEF_MAX_FAILS    = 2;
    localparam int unsigned c_DEF_HOLD_LIMIT   = 3;

endpackage

`default_nettype wire

// File: rtl/wieg_regelaar_if.sv
// ============================================================================
// Module   : wieg_regelaar_if
// Purpose  : Stress verdict in, motor setpoints out, for the rocking loop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wieg_regelaar_if
    import wieg_regelaar_pkg::*;
#(
    parameter int unsigned W = c_DEF_W
) ();

    logic         slow;
    logic         gedaald;
    logic         gelijk;
    logic [W-1:0] freq;
    logic [W-1:0] amp;
    logic         wijzig;
    logic         klaar;

    // master is the stress/motor side, slave is the controller
    modport master (
        output slow, gedaald, gelijk,
        input  freq, amp, wijzig, klaar
    );

    modport slave (
        input  slow, gedaald, gelijk,
        output freq, amp, wijzig, klaar
    );

endinterface

`default_nettype wire

// File: rtl/wieg_stap.sv
// ============================================================================
// Module   : wieg_stap
// Purpose  : Combinational +/-1 step that bounces off the saturation bounds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wieg_stap #(
    parameter int unsigned W = 4
) (
    input  wire logic [W-1:0] i_val,
    input  wire logic         i_dir,    // 0 = up, 1 = down
    input  wire logic [W-1:0] i_min,
    input  wire logic [W-1:0] i_max,
    output logic      [W-1:0] o_val,
    output logic              o_flip
);

    localparam logic [W:0] c_ONE = (W+1)'(1);

    logic [W:0] w_up;
    logic [W:0] w_dn;
    logic [W:0] w_try;
    logic [W:0] w_alt;
    logic       w_ok;

    // One extra bit so that both overflow past max and underflow below 0 show up
    always_comb begin
        w_up   = {1'b0, i_val} + c_ONE;
        w_dn   = {1'b0, i_val} - c_ONE;
        w_try  = i_dir ? w_dn : w_up;
        w_alt  = i_dir ? w_up : w_dn;
        w_ok   = (w_try >= {1'b0, i_min}) && (w_try <= {1'b0, i_max});
        o_val  = w_ok ? w_try[W-1:0] : w_alt[W-1:0];
        o_flip = ~w_ok;
    end

endmodule

`default_nettype wire

// File: rtl/wieg_regelaar.sv
// ============================================================================
// Module   : wieg_regelaar
// Purpose  : Hill-climbing frequency/amplitude search that locks on level stress.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wieg_regelaar
    import wieg_regelaar_pkg::*;
#(
    parameter int unsigned W            = c_DEF_W,
    parameter int unsigned FREQ_INIT    = c_DEF_FREQ_INIT,
    parameter int unsigned AMP_INIT     = c_DEF_AMP_INIT,
    parameter int unsigned VAL_MIN      = c_DEF_VAL_MIN,
    parameter int unsigned VAL_MAX      = c_DEF_VAL_MAX,
    parameter int unsigned SETTLE_TICKS = c_DEF_SETTLE_TICKS,
    parameter int unsigned MAX_FAILS    = c_DEF_MAX_FAILS,
    parameter int unsigned HOLD_LIMIT   = c_DEF_HOLD_LIMIT
) (
    input  wire logic      clk,
    input  wire logic      reset,
    wieg_regelaar_if.slave bus
);

    localparam int unsigned c_TW = $clog2(SETTLE_TICKS + 1);
    localparam int unsigned c_FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned c_EW = $clog2(HOLD_LIMIT + 1);

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(SETTLE_TICKS - 1);
    localparam logic [c_TW-1:0] c_TICK_ONE  = c_TW'(1);
    localparam logic [c_FW-1:0] c_FAIL_LIM  = c_FW'(MAX_FAILS);
    localparam logic [c_FW-1:0] c_FAIL_ONE  = c_FW'(1);
    localparam logic [c_EW-1:0] c_EQ_LIM    = c_EW'(HOLD_LIMIT);
    localparam logic [c_EW-1:0] c_EQ_ONE    = c_EW'(1);
    localparam logic [W-1:0]    c_FREQ_INIT = W'(FREQ_INIT);
    localparam logic [W-1:0]    c_AMP_INIT  = W'(AMP_INIT);
    localparam logic [W-1:0]    c_MIN       = W'(VAL_MIN);
    localparam logic [W-1:0]    c_MAX       = W'(VAL_MAX);

    state_t          r_state,    w_state_nx;
    sel_t            r_sel,      w_sel_nx;
    logic            r_dir,      w_dir_nx;     // 0 = up, 1 = down
    logic [c_TW-1:0] r_tick_cnt, w_tick_nx;
    logic [c_FW-1:0] r_fails,    w_fails_nx;
    logic [c_EW-1:0] r_eq_cnt,   w_eq_nx;
    logic            r_gd,       w_gd_nx;
    logic            r_gl,       w_gl_nx;
    logic [W-1:0]    r_freq,     w_freq_nx;
    logic [W-1:0]    r_amp,      w_amp_nx;
    logic            r_wijzig,   w_wijzig_nx;
    logic            r_klaar,    w_klaar_nx;

    logic [c_FW-1:0] w_fails_inc;
    logic [c_EW-1:0] w_eq_inc;
    logic [W-1:0]    w_stap_in;
    logic [W-1:0]    w_stap_out;
    logic            w_stap_flip;

    assign w_stap_in = (r_sel == SEL_FREQ) ? r_freq : r_amp;

    wieg_stap #(
        .W (W)
    ) u_stap (
        .i_val  (w_stap_in),
        .i_dir  (r_dir),
        .i_min  (c_MIN),
        .i_max  (c_MAX),
        .o_val  (w_stap_out),
        .o_flip (w_stap_flip)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SETTLE;
            r_sel      <= SEL_FREQ;
            r_dir      <= 1'b0;
            r_tick_cnt <= '0;
            r_fails    <= '0;
            r_eq_cnt   <= '0;
            r_gd       <= 1'b0;
            r_gl       <= 1'b0;
            r_freq     <= c_FREQ_INIT;
            r_amp      <= c_AMP_INIT;
            r_wijzig   <= 1'b0;
            r_klaar    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_dir      <= w_dir_nx;
            r_tick_cnt <= w_tick_nx;
            r_fails    <= w_fails_nx;
            r_eq_cnt   <= w_eq_nx;
            r_gd       <= w_gd_nx;
            r_gl       <= w_gl_nx;
            r_freq     <= w_freq_nx;
            r_amp      <= w_amp_nx;
            r_wijzig   <= w_wijzig_nx;
            r_klaar    <= w_klaar_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_sel_nx    = r_sel;
        w_dir_nx    = r_dir;
        w_tick_nx   = r_tick_cnt;
        w_fails_nx  = r_fails;
        w_eq_nx     = r_eq_cnt;
        w_gd_nx     = r_gd;
        w_gl_nx     = r_gl;
        w_freq_nx   = r_freq;
        w_amp_nx    = r_amp;
        w_wijzig_nx = 1'b0;
        w_klaar_nx  = r_klaar;
        w_fails_inc = r_fails + c_FAIL_ONE;
        w_eq_inc    = r_eq_cnt + c_EQ_ONE;

        case (r_state)
            ST_SETTLE: begin
                if (bus.slow) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_state_nx = ST_EVAL;
                        w_gd_nx    = bus.gedaald;
                        w_gl_nx    = bus.gelijk;
                    end else begin
                        w_tick_nx = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end

            ST_EVAL: begin
                if (r_gd) begin
                    w_fails_nx = '0;
                    w_eq_nx    = '0;
                    w_state_nx = ST_STEP;
                end else if (r_gl) begin
                    w_eq_nx = w_eq_inc;
                    if (w_eq_inc == c_EQ_LIM) begin
                        w_state_nx = ST_HOLD;
                        w_klaar_nx = 1'b1;
                    end else begin
                        w_sel_nx   = (r_sel == SEL_FREQ) ? SEL_AMP : SEL_FREQ;
                        w_dir_nx   = 1'b0;
                        w_fails_nx = '0;
                        w_state_nx = ST_STEP;
                    end
                end else begin
                    // Stress rose: retry the other way, or give up on this setpoint
                    w_eq_nx = '0;
                    if (w_fails_inc == c_FAIL_LIM) begin
                        w_sel_nx   = (r_sel == SEL_FREQ) ? SEL_AMP : SEL_FREQ;
                        w_dir_nx   = 1'b0;
                        w_fails_nx = '0;
                    end else begin
                        w_fails_nx = w_fails_inc;
                        w_dir_nx   = ~r_dir;
                    end
                    w_state_nx = ST_STEP;
                end
            end

            ST_STEP: begin
                if (r_sel == SEL_FREQ) begin
                    w_freq_nx = w_stap_out;
                end else begin
                    w_amp_nx = w_stap_out;
                end
                w_dir_nx    = r_dir ^ w_stap_flip;
                w_tick_nx   = '0;
                w_wijzig_nx = 1'b1;
                w_state_nx  = ST_SETTLE;
            end

            ST_HOLD: begin
                if (bus.slow && !bus.gedaald && !bus.gelijk) begin
                    w_klaar_nx = 1'b0;
                    w_eq_nx    = '0;
                    w_fails_nx = '0;
                    w_dir_nx   = ~r_dir;
                    w_state_nx = ST_STEP;
                end
            end

            default: begin
                w_state_nx = ST_SETTLE;
            end
        endcase
    end

    assign bus.freq   = r_freq;
    assign bus.amp    = r_amp;
    assign bus.wijzig = r_wijzig;
    assign bus.klaar  = r_klaar;

endmodule

`default_nettype wire
